// File: rtl/alu_exec_stage.sv
// alu_exec_stage: issue/writeback wrapper around the combinational ALU_main.
// Registers one operation onto the ALU inputs and gives the ALU one cycle to
// settle. It then captures the result plus N/Z/C/V flags and holds them
// under a valid/ready handshake.
//
// state | meaning
// IDLE  | empty, ready to accept an operation
// EXEC  | operands registered, ALU_main settling on them
// DONE  | result/flags valid, waiting for downstream to take them
module alu_exec_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    logic             is_sub;
    logic             is_arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             accept;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Shadow adder on the latched operands; only C and V are taken from it,
    // the result itself always comes from ALU_main.
    always_comb begin
        is_sub   = (alu_ctrl == OP_SUB);
        is_arith = (alu_ctrl == OP_ADD) || is_sub;
        b_eff    = is_sub ? ~alu_b : alu_b;
        sum      = {1'b0, alu_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        flag_n   = alu_result[WIDTH-1];
        flag_z   = (alu_result == '0);
        flag_c   = is_arith ? sum[WIDTH] : 1'b0;
        flag_v   = is_arith
                   && (alu_a[WIDTH-1] == b_eff[WIDTH-1])
                   && (sum[WIDTH-1] != alu_a[WIDTH-1]);
    end

    // Handshake FSM; operand, result and flag registers are all updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= 4'b0000;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a    <= in_a;
                        alu_b    <= in_b;
                        alu_ctrl <= in_op;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    out_result <= alu_result;
                    out_flags  <= {flag_n, flag_z, flag_c, flag_v};
                    out_valid  <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            alu_a    <= in_a;
                            alu_b    <= in_b;
                            alu_ctrl <= in_op;
                            state    <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural ALU_main attached.
module tb_alu_exec_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_ctrl;
    logic [3:0] alu_result;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [3:0] out_flags;

    int vectors = 0;
    int miscompares = 0;
    int xfers = 0;
    int xfer_base;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    // Behavioural ALU_main
    always_comb begin
        case (alu_ctrl)
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a | alu_b;
            2'b10:   alu_result = alu_a + alu_b;
            default: alu_result = alu_a - alu_b;
        endcase
    end

    // Count completed output handshakes
    always @(posedge clk) begin
        if (out_valid && out_ready) xfers++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    endtask

    // Single operation from IDLE with out_ready high: accept, one EXEC cycle, DONE.
    task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic [3:0] res, input logic [3:0] flg);
        chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        drive(a, b, op);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_op = ~op;
        chk({tag, "_ctrl"}, {6'd0, alu_ctrl}, {6'd0, op});
        chk({tag, "_exec_valid"}, {7'd0, out_valid}, 8'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
        chk({tag, "_result"}, {4'd0, out_result}, {4'd0, res});
        chk({tag, "_flags"}, {4'd0, out_flags}, {4'd0, flg});
        @(posedge clk); #1;
        chk({tag, "_idle"}, {7'd0, out_valid}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        drive(4'b1010, 4'b0101, 2'b10);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_result", {4'd0, out_result}, 8'd0);
        chk("rst_flags", {4'd0, out_flags}, 8'd0);
        chk("rst_alu_a", {4'd0, alu_a}, 8'd0);
        chk("rst_alu_ctrl", {6'd0, alu_ctrl}, 8'd0);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        @(posedge clk); #1;

        //      tag      A        B        op     result   {N,Z,C,V}
        do_op("and",  4'b1011, 4'b0010, 2'b00, 4'b0010, 4'b0000);
        do_op("or",   4'b1001, 4'b0100, 2'b01, 4'b1101, 4'b1000);
        do_op("addc", 4'b1110, 4'b1110, 2'b10, 4'b1100, 4'b1010);
        do_op("addv", 4'b0111, 4'b0001, 2'b10, 4'b1000, 4'b1001);
        do_op("sub",  4'b1111, 4'b0111, 2'b11, 4'b1000, 4'b1010);
        do_op("subz", 4'b0101, 4'b0101, 2'b11, 4'b0000, 4'b0110);

        // Back-pressure: 0011 + 0100 = 0111, flags 0000
        out_ready = 1'b0;
        drive(4'b0011, 4'b0100, 2'b10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        xfer_base = xfers;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {7'd0, out_valid}, 8'd1);
            chk("bp_result", {4'd0, out_result}, 8'b0111);
            chk("bp_flags", {4'd0, out_flags}, 8'b0000);
            chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_in_ready", {7'd0, in_ready}, 8'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_one_xfer", xfers[7:0] - xfer_base[7:0], 8'd1);
        chk("bp_after_valid", {7'd0, out_valid}, 8'd0);

        // Back-to-back with in_valid and out_ready held high
        xfer_base = xfers;
        drive(4'b0001, 4'b0010, 2'b10);                // op1: 0011, 0000
        @(posedge clk); #1;
        drive(4'b0110, 4'b0011, 2'b11);                // op2: 0011, 0010
        @(posedge clk); #1;
        chk("b2b1_valid", {7'd0, out_valid}, 8'd1);
        chk("b2b1_result", {4'd0, out_result}, 8'b0011);
        chk("b2b1_flags", {4'd0, out_flags}, 8'b0000);
        chk("b2b1_in_ready", {7'd0, in_ready}, 8'd1);
        @(posedge clk); #1;
        chk("b2b2_exec_valid", {7'd0, out_valid}, 8'd0);
        chk("b2b2_ctrl", {6'd0, alu_ctrl}, 8'b11);
        drive(4'b1100, 4'b1010, 2'b00);                // op3: dropped by reset
        @(posedge clk); #1;
        chk("b2b2_result", {4'd0, out_result}, 8'b0011);
        chk("b2b2_flags", {4'd0, out_flags}, 8'b0010);
        @(posedge clk); #1;
        chk("b2b3_ctrl", {6'd0, alu_ctrl}, 8'b00);
        drive(4'b0100, 4'b0100, 2'b10);                // op4 queued: 1000, 1001
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_result", {4'd0, out_result}, 8'd0);
        chk("mid_rst_flags", {4'd0, out_flags}, 8'd0);
        chk("mid_rst_alu_a", {4'd0, alu_a}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_hold_a", {4'd0, alu_a}, 8'd0);
        chk("mid_rst_hold_valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_alu_a", {4'd0, alu_a}, 8'b0100);
        chk("post_rst_ctrl", {6'd0, alu_ctrl}, 8'b10);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_valid", {7'd0, out_valid}, 8'd1);
        chk("post_rst_result", {4'd0, out_result}, 8'b1000);
        chk("post_rst_flags", {4'd0, out_flags}, 8'b1001);
        @(posedge clk); #1;
        // op1, op2 and the post-reset op4 transferred; op3 never produced
        chk("b2b_xfers", xfers[7:0] - xfer_base[7:0], 8'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

endmodule
